conv_enc_322: RTL

Rate-2/3 (3,2,2) convolutional encoder with framing, the transmit-side counterpart of the (3,2,2) Viterbi decoder. It accepts 2-bit input pairs through a valid/ready handshake and emits one 3-bit code symbol per pair. Each symbol carries a frame stage index so the decoder's stage count and out-of-sync checks line up with the transmitter. Every frame is terminated with one tail symbol that returns the encoder to state 00.

---
 rtl/conv_enc_322_if.sv | 24 ++
 rtl/conv_enc_322.sv | 133 +++++++++++++
 2 files changed

// File: rtl/conv_enc_322_if.sv
// Handshake and status bundle for the rate-2/3 (3,2,2) convolutional encoder.
interface conv_enc_322_if;
  logic       start;
  logic       in_valid;
  logic [1:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_code;
  logic [3:0] out_stage;
  logic       out_last;
  logic       busy;
  logic       done;

  modport master (
    output start, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_code, out_stage, out_last, busy, done
  );

  modport slave (
    input  start, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_code, out_stage, out_last, busy, done
  );
endinterface

// File: rtl/conv_enc_322.sv
// Rate-2/3 (3,2,2) convolutional encoder with per-frame stage numbering and a
// single tail symbol that drives the encoder state back to 00.
//
// state  | meaning
// IDLE   | waiting for start; a tail symbol may still sit in the output slot
// ENCODE | accepting data pairs, one code symbol per pair
// FLUSH  | all pairs taken; emit the tail symbol (u=00) at the next free slot
module conv_enc_322 #(
  parameter int FRAME_LEN = 16
) (
  input  logic          clock,
  input  logic          reset,
  conv_enc_322_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, ENCODE = 2'd1, FLUSH = 2'd2} state_t;

  localparam logic [7:0] LastPair = 8'(FRAME_LEN);

  state_t     state_q, state_d;
  logic [1:0] s_q, s_d;
  logic [7:0] pair_q, pair_d;
  logic [3:0] stage_q, stage_d;
  logic       out_valid_q, out_valid_d;
  logic [2:0] out_code_q, out_code_d;
  logic [3:0] out_stage_q, out_stage_d;
  logic       out_last_q, out_last_d;
  logic       done_q, done_d;

  logic       slot_free;
  logic       in_ready;
  logic       accept;
  logic [3:0] stage_inc;

  function automatic logic [2:0] encode(input logic [1:0] u, input logic [1:0] s);
    encode = {u[1] ^ s[1] ^ s[0], u[0] ^ s[1], u[1] ^ u[0] ^ s[0]};
  endfunction

  assign slot_free = !out_valid_q || bus.out_ready;
  assign in_ready  = (state_q == ENCODE) && slot_free;
  assign accept    = in_ready && bus.in_valid;
  // Stage index sticks at 15 so long frames keep a valid 4-bit label.
  assign stage_inc = (stage_q == 4'hF) ? stage_q : stage_q + 4'd1;

  // Next-state logic: FSM, encoder memory, counters and the output slot.
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    pair_d      = pair_q;
    stage_d     = stage_q;
    out_valid_d = out_valid_q;
    out_code_d  = out_code_q;
    out_stage_d = out_stage_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
      done_d      = out_last_q;
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          s_d     = 2'b00;
          pair_d  = 8'd0;
          stage_d = 4'd0;
          state_d = ENCODE;
        end
      end
      ENCODE: begin
        if (accept) begin
          out_code_d  = encode(bus.in_data, s_q);
          out_stage_d = stage_q;
          out_last_d  = 1'b0;
          out_valid_d = 1'b1;
          s_d         = bus.in_data;
          pair_d      = pair_q + 8'd1;
          stage_d     = stage_inc;
          if (pair_q + 8'd1 == LastPair) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (slot_free) begin
          out_code_d  = encode(2'b00, s_q);
          out_stage_d = stage_q;
          out_last_d  = 1'b1;
          out_valid_d = 1'b1;
          s_d         = 2'b00;
          stage_d     = stage_inc;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops everything, including a pending symbol.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      s_q         <= 2'b00;
      pair_q      <= 8'd0;
      stage_q     <= 4'd0;
      out_valid_q <= 1'b0;
      out_code_q  <= 3'b000;
      out_stage_q <= 4'd0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      pair_q      <= pair_d;
      stage_q     <= stage_d;
      out_valid_q <= out_valid_d;
      out_code_q  <= out_code_d;
      out_stage_q <= out_stage_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_code  = out_code_q;
  assign bus.out_stage = out_stage_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;

endmodule
